// File: rtl/dm_access_pkg.sv
// dm_access_pkg: shared encodings for the data-memory access unit.
// Holds the size codes, error codes and FSM state type used by dm_access and dm_lane.
package dm_access_pkg;

    localparam logic [1:0] MEMSIZE_W = 2'b00;
    localparam logic [1:0] MEMSIZE_H = 2'b01;
    localparam logic [1:0] MEMSIZE_B = 2'b10;

    localparam logic [1:0] DMERR_NONE  = 2'b00;
    localparam logic [1:0] DMERR_ALIGN = 2'b01;
    localparam logic [1:0] DMERR_TMO   = 2'b10;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'b00,
        DMA_REQ  = 2'b01,
        DMA_DONE = 2'b10,
        DMA_ERR  = 2'b11
    } dma_state_e;

endpackage

// File: rtl/dm_access_lane.sv
// dm_lane: little-endian lane steering for the data-memory bus.
// Produces byte enables, replicated store data, extended load data and the misalign flag.
module dm_lane
    import dm_access_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_bus_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rext,
    output logic        o_misalign
);

    logic        w_half;
    logic        w_byte;
    logic        w_word;
    logic [15:0] w_hw;
    logic [7:0]  w_b;

    // reserved size code 11 falls through to word
    assign w_half     = i_size == MEMSIZE_H;
    assign w_byte     = i_size == MEMSIZE_B;
    assign w_word     = !w_half && !w_byte;
    assign w_hw       = i_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    assign w_b        = i_off[0] ? w_hw[15:8] : w_hw[7:0];
    assign o_misalign = w_word ? |i_off : w_half & i_off[0];
    assign o_be       = w_word ? 4'b1111 : (w_half ? 4'b0011 : 4'b0001) << i_off;
    assign o_wdata    = w_word ? i_wdata : w_half ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
    assign o_rext     = w_word ? i_bus_rdata
                      : w_half ? {{16{i_sign & w_hw[15]}}, w_hw}
                      : {{24{i_sign & w_b[7]}}, w_b};

endmodule

// File: rtl/dm_access.sv
// dm_access: multicycle data-memory access unit running one req/ack bus transaction per start.
// Owns the FSM, the latched request and the bus timeout counter; lane steering lives in dm_lane.
module dm_access
    import dm_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    dma_state_e  r_state;
    dma_state_e  w_next;
    logic [31:0] r_addr;
    logic [31:0] r_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_be;
    logic [1:0]  r_size;
    logic [1:0]  r_err_code;
    logic        r_we;
    logic        r_sign;
    logic        w_idle;
    logic        w_accept;
    logic        w_ack;
    logic        w_tmo;
    logic        w_mis;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rext;

    assign w_idle   = r_state == DMA_IDLE;
    assign w_accept = w_idle && i_start;
    assign w_ack    = r_state == DMA_REQ && i_bus_ack;
    // an ack arriving on the final allowed cycle wins over the timeout
    assign w_tmo    = r_state == DMA_REQ && !i_bus_ack && TIMEOUT != 0 && r_cnt == 32'(TIMEOUT - 1);

    // live inputs feed the lane logic in IDLE, latched values while the bus is busy
    dm_lane u_lane (
        .i_off       (w_idle ? i_addr[1:0] : r_addr[1:0]),
        .i_size      (w_idle ? i_size : r_size),
        .i_sign      (w_idle ? i_sign : r_sign),
        .i_wdata     (i_wdata),
        .i_bus_rdata (i_bus_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .o_rext      (w_rext),
        .o_misalign  (w_mis)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= DMA_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            DMA_IDLE: w_next = !i_start ? DMA_IDLE : w_mis ? DMA_ERR : DMA_REQ;
            DMA_REQ:  w_next = w_ack ? DMA_DONE : w_tmo ? DMA_ERR : DMA_REQ;
            default:  w_next = DMA_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_bus_wdata <= '0;
            r_be        <= '0;
            r_size      <= '0;
            r_err_code  <= DMERR_NONE;
            r_we        <= 1'b0;
            r_sign      <= 1'b0;
        end else begin
            if (w_accept && !w_mis) begin
                r_addr      <= i_addr;
                r_we        <= i_we;
                r_size      <= i_size;
                r_sign      <= i_sign;
                r_be        <= w_be;
                r_bus_wdata <= w_wdata;
            end
            r_cnt      <= r_state == DMA_REQ ? r_cnt + 32'd1 : '0;
            r_err_code <= w_accept && w_mis ? DMERR_ALIGN : w_tmo ? DMERR_TMO : DMERR_NONE;
            if (w_ack && !r_we) r_rdata <= w_rext;
        end
    end

    assign o_rdata     = r_rdata;
    assign o_busy      = !w_idle;
    assign o_done      = r_state == DMA_DONE || r_state == DMA_ERR;
    assign o_err       = r_state == DMA_ERR;
    assign o_err_code  = r_err_code;
    assign o_bus_req   = r_state == DMA_REQ;
    assign o_bus_we    = r_we;
    assign o_bus_addr  = {r_addr[31:2], 2'b00};
    assign o_bus_be    = r_be;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dm_access.sv
// tb_dm_access: directed scenarios for dm_access with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dm_access;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_we = 1'b0;
    logic [1:0]  i_size = 2'b00;
    logic        i_sign = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [31:0] i_bus_rdata = '0;
    logic        i_bus_ack = 1'b0;
    logic [31:0] o_rdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    int total = 0;
    int bad = 0;

    always #5 i_clk = ~i_clk;

    dm_access #(.TIMEOUT(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_sign      (i_sign),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_be    (o_bus_be),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_rdata (i_bus_rdata),
        .i_bus_ack   (i_bus_ack)
    );

    // start is sampled on the next rising edge; returns in the first cycle after acceptance
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        i_we = we; i_size = sz; i_sign = sg; i_addr = a; i_wdata = wd; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        total++; if ({o_busy, o_done, o_err, o_err_code, o_bus_req, o_bus_we, o_bus_be} !== 11'h0) begin
            bad++; $display("FAIL reset_ctrl got=%h exp=0", {o_busy, o_done, o_err, o_err_code, o_bus_req, o_bus_we, o_bus_be});
        end
        total++; if ({o_rdata, o_bus_addr, o_bus_wdata} !== 96'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", o_rdata, o_bus_addr, o_bus_wdata);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_lw;
        issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        total++; if (o_bus_req !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            bad++; $display("FAIL lw_req req=%b busy=%b done=%b exp=1/1/0", o_bus_req, o_busy, o_done);
        end
        total++; if (o_bus_be !== 4'b1111 || o_bus_addr !== 32'h100 || o_bus_we !== 1'b0) begin
            bad++; $display("FAIL lw_bus be=%b addr=%h we=%b exp=1111/00000100/0", o_bus_be, o_bus_addr, o_bus_we);
        end
        i_bus_rdata = 32'hDEADBEEF; i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        total++; if (o_done !== 1'b1 || o_err !== 1'b0 || o_bus_req !== 1'b0 || o_busy !== 1'b1) begin
            bad++; $display("FAIL lw_done done=%b err=%b req=%b busy=%b exp=1/0/0/1", o_done, o_err, o_bus_req, o_busy);
        end
        total++; if (o_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", o_rdata);
        end
        @(negedge i_clk);
        total++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL lw_idle done=%b busy=%b exp=0/0", o_done, o_busy);
        end
    endtask

    task automatic test_lb_lbu;
        issue(1'b0, 2'b10, 1'b1, 32'h103, 32'h0);
        total++; if (o_bus_be !== 4'b1000) begin
            bad++; $display("FAIL lb_be got=%b exp=1000", o_bus_be);
        end
        i_bus_rdata = 32'h80123456; i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        total++; if (o_done !== 1'b1 || o_rdata !== 32'hFFFFFF80) begin
            bad++; $display("FAIL lb_rdata done=%b got=%h exp=1/ffffff80", o_done, o_rdata);
        end
        @(negedge i_clk);
        issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        total++; if (o_bus_be !== 4'b1100) begin
            bad++; $display("FAIL lh_be got=%b exp=1100", o_bus_be);
        end
        i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        total++; if (o_rdata !== 32'hFFFF8012) begin
            bad++; $display("FAIL lh_rdata got=%h exp=ffff8012", o_rdata);
        end
        @(negedge i_clk);
        issue(1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
        i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        total++; if (o_done !== 1'b1 || o_rdata !== 32'h00000080) begin
            bad++; $display("FAIL lbu_rdata done=%b got=%h exp=1/00000080", o_done, o_rdata);
        end
        @(negedge i_clk);
    endtask

    task automatic test_sh;
        issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
        i_wdata = 32'h11111111;
        for (int k = 0; k < 4; k++) begin
            total++; if (o_bus_req !== 1'b1 || o_bus_we !== 1'b1 || o_done !== 1'b0) begin
                bad++; $display("FAIL sh_req_%0d req=%b we=%b done=%b exp=1/1/0", k, o_bus_req, o_bus_we, o_done);
            end
            total++; if (o_bus_be !== 4'b1100 || o_bus_wdata !== 32'hABCDABCD || o_bus_addr !== 32'h200) begin
                bad++; $display("FAIL sh_bus_%0d be=%b wdata=%h addr=%h exp=1100/abcdabcd/00000200", k, o_bus_be, o_bus_wdata, o_bus_addr);
            end
            i_bus_ack = (k == 3);
            @(negedge i_clk);
        end
        i_bus_ack = 1'b0;
        total++; if (o_done !== 1'b1 || o_err !== 1'b0 || o_bus_req !== 1'b0) begin
            bad++; $display("FAIL sh_done done=%b err=%b req=%b exp=1/0/0", o_done, o_err, o_bus_req);
        end
        total++; if (o_rdata !== 32'h00000080) begin
            bad++; $display("FAIL sh_rdata got=%h exp=00000080", o_rdata);
        end
        @(negedge i_clk);
    endtask

    task automatic test_misaligned;
        issue(1'b0, 2'b00, 1'b0, 32'h106, 32'h0);
        total++; if (o_done !== 1'b1 || o_err !== 1'b1 || o_err_code !== 2'b01 || o_bus_req !== 1'b0) begin
            bad++; $display("FAIL mis_err done=%b err=%b code=%b req=%b exp=1/1/01/0", o_done, o_err, o_err_code, o_bus_req);
        end
        total++; if (o_rdata !== 32'h00000080) begin
            bad++; $display("FAIL mis_rdata got=%h exp=00000080", o_rdata);
        end
        @(negedge i_clk);
        total++; if (o_done !== 1'b0 || o_bus_req !== 1'b0 || o_err !== 1'b0) begin
            bad++; $display("FAIL mis_after done=%b req=%b err=%b exp=0/0/0", o_done, o_bus_req, o_err);
        end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 2'b10, 1'b0, 32'h201, 32'h0000005A);
        total++; if (o_bus_be !== 4'b0010 || o_bus_wdata !== 32'h5A5A5A5A) begin
            bad++; $display("FAIL sb_bus be=%b wdata=%h exp=0010/5a5a5a5a", o_bus_be, o_bus_wdata);
        end
        i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        total++; if (o_done !== 1'b1) begin
            bad++; $display("FAIL b2b_done1 got=%b exp=1", o_done);
        end
        @(negedge i_clk);
        issue(1'b0, 2'b01, 1'b0, 32'h0A2, 32'h0);
        total++; if (o_bus_req !== 1'b1 || o_bus_be !== 4'b1100 || o_bus_we !== 1'b0) begin
            bad++; $display("FAIL b2b_req req=%b be=%b we=%b exp=1/1100/0", o_bus_req, o_bus_be, o_bus_we);
        end
        i_bus_rdata = 32'hF00D1234; i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        total++; if (o_done !== 1'b1 || o_rdata !== 32'h0000F00D) begin
            bad++; $display("FAIL lhu_rdata done=%b got=%h exp=1/0000f00d", o_done, o_rdata);
        end
        @(negedge i_clk);
    endtask

    task automatic test_timeout;
        int req_n = 0;
        int done_n = 0;
        issue(1'b0, 2'b00, 1'b0, 32'h300, 32'h0);
        for (int k = 0; k < 8; k++) begin
            if (o_bus_req) req_n++;
            if (o_done) begin
                done_n++;
                total++; if (o_err !== 1'b1 || o_err_code !== 2'b10 || o_bus_req !== 1'b0) begin
                    bad++; $display("FAIL tmo_err err=%b code=%b req=%b exp=1/10/0", o_err, o_err_code, o_bus_req);
                end
            end
            i_start = (k == 1);
            i_addr  = 32'h380;
            @(negedge i_clk);
        end
        i_start = 1'b0;
        total++; if (req_n != 4) begin
            bad++; $display("FAIL tmo_req_cycles got=%0d exp=4", req_n);
        end
        total++; if (done_n != 1) begin
            bad++; $display("FAIL tmo_done_pulses got=%0d exp=1", done_n);
        end
        total++; if (o_bus_addr !== 32'h300 || o_busy !== 1'b0) begin
            bad++; $display("FAIL tmo_ignore_start addr=%h busy=%b exp=00000300/0", o_bus_addr, o_busy);
        end
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 2'b00, 1'b0, 32'h400, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        total++; if (o_bus_req !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_rdata !== 32'h0) begin
            bad++; $display("FAIL rstmid_outs req=%b busy=%b done=%b rdata=%h exp=0/0/0/0", o_bus_req, o_busy, o_done, o_rdata);
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        total++; if (o_done !== 1'b0 || o_bus_req !== 1'b0) begin
            bad++; $display("FAIL rstmid_nodone done=%b req=%b exp=0/0", o_done, o_bus_req);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h500, 32'h0);
        i_bus_rdata = 32'h12345678; i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        total++; if (o_done !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'h12345678) begin
            bad++; $display("FAIL rstmid_next done=%b err=%b rdata=%h exp=1/0/12345678", o_done, o_err, o_rdata);
        end
        @(negedge i_clk);
    endtask

    initial begin
        test_reset;
        test_lw;
        test_lb_lbu;
        test_sh;
        test_misaligned;
        test_back_to_back;
        test_timeout;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
